// File: rtl/sd_spi_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdspi_types (package)
//  Description : Shared types and default constants for the SD-card SPI
//                engine: operation codes, FSM state encoding and the
//                default SCLK divider / dummy-byte settings.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdspi_types;

   // Operation requests from the sector state machine. spiopDUMMY stays
   // reserved even when the dummy-clock feature is compiled out.
   typedef enum logic [2:0] {
      spiopNOP   = 3'd0,
      spiopCSL   = 3'd1,
      spiopCSH   = 3'd2,
      spiopSLOW  = 3'd3,
      spiopFAST  = 3'd4,
      spiopTR    = 3'd5,
      spiopDUMMY = 3'd6
   } spiOP_t;

   // Engine state encoding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } spiSTATE_t;

   // Default half-period dividers (clk cycles) and dummy byte count.
   localparam int c_SLOW_DIV_DFLT    = 63;
   localparam int c_FAST_DIV_DFLT    = 2;
   localparam int c_DUMMY_BYTES_DFLT = 10;

endpackage : sdspi_types
`default_nettype wire

// File: rtl/sd_spi_engine_clkdiv.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_clkdiv
//  Description : SCLK half-period counter. Counts up from 0 while enabled
//                and pulses tick on the last cycle of each half-period,
//                restarting from 0. A load restarts the count for a new
//                transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_clkdiv #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] div,
   output logic         tick
);

   logic [W-1:0] r_count;

   assign tick = enable && !load && (r_count == (div - W'(1)));

   // Half-period counter: restart on load, boundary or abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear || load || tick) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + W'(1);
      end
   end

endmodule : sd_spi_clkdiv
`default_nettype wire

// File: rtl/sd_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_engine
//  Description : Byte-level SPI master (mode 0, first bit = spiTXD[0]) for
//                the SD-card interface. Owns chip select, slow/fast SCLK
//                rates and full-duplex 8-bit transfers.
//  Options     : define SD_SPI_DUMMY_EN to add spiopDUMMY (DUMMY_BYTES
//                bytes of 0xFF with CS forced high). Without it,
//                spiopDUMMY is ignored like spiopNOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_engine
   import sdspi_types::*;
#(
   parameter int SLOW_DIV    = c_SLOW_DIV_DFLT,
   parameter int FAST_DIV    = c_FAST_DIV_DFLT,
   parameter int DUMMY_BYTES = c_DUMMY_BYTES_DFLT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  spiOP_t     spiOP,
   input  logic [0:7] spiTXD,
   output logic [0:7] spiRXD,
   output logic       spiBUSY,
   output logic       spiDONE,
   input  logic       sdMISO,
   output logic       sdMOSI,
   output logic       sdSCLK,
   output logic       sdCS
);

   localparam int DIVW = $clog2(SLOW_DIV + 1);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_LO   = LO;
   localparam logic [1:0] ST_HI   = HI;
   localparam logic [1:0] ST_DONE = DONE;

   // Elaboration-time sanity check of the configuration.
   if (FAST_DIV < 1 || SLOW_DIV < 1 || DUMMY_BYTES < 1) begin : g_badParam
      $error("sd_spi_engine: dividers and DUMMY_BYTES must be at least 1");
   end

   logic [1:0]      r_state;
   logic            r_cs;
   logic            r_sclk;
   logic            r_mosi;
   logic [0:7]      r_rxd;
   logic [0:7]      r_shift;
   logic            r_fast;
   logic [DIVW-1:0] r_div;
   logic [2:0]      r_bitCnt;

   logic            w_load;
   logic            w_enable;
   logic            w_tick;
   logic            w_misoIn;
   logic            w_moreBytes;
   logic            w_isDummy;
   logic [DIVW-1:0] w_divSel;

`ifdef SD_SPI_DUMMY_EN
   localparam int BCW = $clog2(DUMMY_BYTES + 1);

   logic           r_isDummy;
   logic           r_csSave;
   logic [BCW-1:0] r_byteCnt;

   assign w_isDummy   = r_isDummy;
   assign w_moreBytes = r_isDummy && (r_byteCnt != BCW'(DUMMY_BYTES - 1));
   assign w_load      = (r_state == ST_IDLE) &&
                        ((spiOP == spiopTR) || (spiOP == spiopDUMMY));
`else
   assign w_isDummy   = 1'b0;
   assign w_moreBytes = 1'b0;
   assign w_load      = (r_state == ST_IDLE) && (spiOP == spiopTR);
`endif

   // Dummy clocks shift in ones so MISO never disturbs the shift register.
   assign w_misoIn = w_isDummy ? 1'b1 : sdMISO;
   assign w_enable = (r_state == ST_LO) || (r_state == ST_HI);
   assign w_divSel = r_fast ? DIVW'(FAST_DIV) : DIVW'(SLOW_DIV);

   sd_spi_clkdiv #(
      .W      (DIVW)
   ) u_clkdiv (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .load   (w_load),
      .enable (w_enable),
      .div    (r_div),
      .tick   (w_tick)
   );

`ifdef SD_SPI_DUMMY_EN
   // Dummy-op bookkeeping: byte count and chip-select level to restore.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_isDummy <= 1'b0;
         r_csSave  <= 1'b1;
         r_byteCnt <= '0;
      end else if (clear) begin
         r_isDummy <= 1'b0;
         r_csSave  <= 1'b1;
         r_byteCnt <= '0;
      end else if (r_state == ST_IDLE) begin
         if (spiOP == spiopDUMMY) begin
            r_isDummy <= 1'b1;
            r_csSave  <= r_cs;
            r_byteCnt <= '0;
         end else if (spiOP == spiopTR) begin
            r_isDummy <= 1'b0;
         end
      end else if (r_state == ST_HI && w_tick && r_bitCnt == 3'd7 && w_moreBytes) begin
         r_byteCnt <= r_byteCnt + BCW'(1);
      end
   end
`endif

   // Main engine: op decode in IDLE, LO/HI half-periods per bit, DONE pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cs     <= 1'b1;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b1;
         r_rxd    <= '0;
         r_shift  <= '0;
         r_fast   <= 1'b0;
         r_div    <= '0;
         r_bitCnt <= '0;
      end else if (clear) begin
         r_state  <= ST_IDLE;
         r_cs     <= 1'b1;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b1;
         r_rxd    <= '0;
         r_shift  <= '0;
         r_fast   <= 1'b0;
         r_div    <= '0;
         r_bitCnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               case (spiOP)
                  spiopCSL:  begin r_cs   <= 1'b0; r_state <= ST_DONE; end
                  spiopCSH:  begin r_cs   <= 1'b1; r_state <= ST_DONE; end
                  spiopSLOW: begin r_fast <= 1'b0; r_state <= ST_DONE; end
                  spiopFAST: begin r_fast <= 1'b1; r_state <= ST_DONE; end
                  spiopTR: begin
                     r_shift  <= spiTXD;
                     r_mosi   <= spiTXD[0];
                     r_div    <= w_divSel;
                     r_bitCnt <= '0;
                     r_state  <= ST_LO;
                  end
`ifdef SD_SPI_DUMMY_EN
                  spiopDUMMY: begin
                     r_shift  <= 8'hFF;
                     r_mosi   <= 1'b1;
                     r_cs     <= 1'b1;
                     r_div    <= w_divSel;
                     r_bitCnt <= '0;
                     r_state  <= ST_LO;
                  end
`endif
                  default: ;
               endcase
            end
            ST_LO: begin
               if (w_tick) begin
                  // Rising SCLK edge and MISO sample happen together.
                  r_sclk  <= 1'b1;
                  r_shift <= {r_shift[1:7], w_misoIn};
                  r_state <= ST_HI;
               end
            end
            ST_HI: begin
               if (w_tick) begin
                  r_sclk <= 1'b0;
                  if (r_bitCnt == 3'd7) begin
                     r_bitCnt <= '0;
                     if (w_moreBytes) begin
                        r_mosi  <= 1'b1;
                        r_state <= ST_LO;
                     end else begin
                        r_mosi  <= 1'b1;
                        r_state <= ST_DONE;
                        if (!w_isDummy) begin
                           r_rxd <= r_shift;
                        end
`ifdef SD_SPI_DUMMY_EN
                        if (r_isDummy) begin
                           r_cs <= r_csSave;
                        end
`endif
                     end
                  end else begin
                     r_bitCnt <= r_bitCnt + 3'd1;
                     r_mosi   <= r_shift[0];
                     r_state  <= ST_LO;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign spiRXD  = r_rxd;
   assign spiBUSY = (r_state != ST_IDLE);
   assign spiDONE = (r_state == ST_DONE);
   assign sdMOSI  = r_mosi;
   assign sdSCLK  = r_sclk;
   assign sdCS    = r_cs;

endmodule : sd_spi_engine
`default_nettype wire

// File: tb/tb_sd_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_engine
//  Description : Directed self-checking bench for sd_spi_engine with
//                default parameters (SLOW_DIV=63, FAST_DIV=2,
//                DUMMY_BYTES=10). Covers SD_SPI_DUMMY_EN both ways.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_engine;
   import sdspi_types::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   spiOP_t     spiOP;
   logic [0:7] spiTXD;
   logic [0:7] spiRXD;
   logic       spiBUSY;
   logic       spiDONE;
   logic       sdMISO;
   logic       sdMOSI;
   logic       sdSCLK;
   logic       sdCS;

   int checks   = 0;
   int failures = 0;

   // Monitor state, updated on the falling clk edge.
   int         riseCnt   = 0;
   int         doneCnt   = 0;
   int         glitchCnt = 0;
   int         hiRun     = 0;
   int         lastHiLen = 0;
   int         csViol    = 0;
   int         dumViol   = 0;
   logic       prevSclk  = 1'b0;
   logic       mosiAtRise = 1'b1;
   logic [7:0] mosiBits  = 8'h00;

   // Stimulus-side controls.
   logic       loopMode = 1'b1;
   logic [7:0] respByte = 8'h00;
   int         riseBase = 0;
   logic       csWatch  = 1'b0;
   logic       dumWatch = 1'b0;

   always #5 clk = ~clk;

   // Card model: loopback, or a responder presenting respByte MSB first.
   assign sdMISO = loopMode ? sdMOSI :
                   ((riseCnt - riseBase) < 8) ? respByte[7 - (riseCnt - riseBase)] : 1'b1;

   sd_spi_engine dut (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .spiOP   (spiOP),
      .spiTXD  (spiTXD),
      .spiRXD  (spiRXD),
      .spiBUSY (spiBUSY),
      .spiDONE (spiDONE),
      .sdMISO  (sdMISO),
      .sdMOSI  (sdMOSI),
      .sdSCLK  (sdSCLK),
      .sdCS    (sdCS)
   );

   // Pin monitor: SCLK edges, MOSI stability, high-phase length, DONE pulses.
   always @(negedge clk) begin
      if (sdSCLK && !prevSclk) begin
         riseCnt++;
         mosiBits   = {mosiBits[6:0], sdMOSI};
         mosiAtRise = sdMOSI;
      end
      if (sdSCLK && prevSclk && sdMOSI !== mosiAtRise) glitchCnt++;
      if (sdSCLK) hiRun++;
      else if (prevSclk) begin
         lastHiLen = hiRun;
         hiRun = 0;
      end
      if (csWatch && spiBUSY && !spiDONE && sdCS !== 1'b0) csViol++;
      if (dumWatch && spiBUSY && !spiDONE && (sdCS !== 1'b1 || sdMOSI !== 1'b1)) dumViol++;
      if (spiDONE) doneCnt++;
      prevSclk = sdSCLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present an op for one cycle; on return we are in cycle 1 after acceptance.
   task automatic startOp(input spiOP_t op, input logic [7:0] txd);
      spiOP  = op;
      spiTXD = txd;
      cyc(1);
      spiOP  = spiopNOP;
   endtask

   // Advance until spiDONE is seen; lat is the cycle index from acceptance.
   task automatic waitDone(inout int lat);
      while (spiDONE !== 1'b1 && lat < 20000) begin
         cyc(1);
         lat++;
      end
   endtask

   task automatic doOp(input spiOP_t op, input logic [7:0] txd, output int lat);
      startOp(op, txd);
      lat = 1;
      waitDone(lat);
      cyc(1);
   endtask

   initial begin
      int lat;
      int d0;
      int r0;

      reset  = 1'b1;
      clear  = 1'b0;
      spiOP  = spiopNOP;
      spiTXD = 8'h00;
      cyc(3);

      // Reset state
      check("rst_cs",   sdCS,    1'b1);
      check("rst_sclk", sdSCLK,  1'b0);
      check("rst_mosi", sdMOSI,  1'b1);
      check("rst_rxd",  spiRXD,  8'h00);
      check("rst_busy", spiBUSY, 1'b0);
      check("rst_done", spiDONE, 1'b0);
      reset = 1'b0;
      cyc(2);

      // Fast mode, then loopback transfer of A5
      doOp(spiopFAST, 8'h00, lat);
      check("fast_lat", lat, 1);
      check("fast_no_sclk", riseCnt, 0);
      loopMode = 1'b1;
      r0 = riseCnt;
      doOp(spiopTR, 8'hA5, lat);
      check("loop_lat", lat, 33);
      check("loop_rxd", spiRXD, 8'hA5);
      check("loop_rises", riseCnt - r0, 8);
      check("loop_mosi_bits", mosiBits, 8'hA5);
      check("loop_mosi_stable", glitchCnt, 0);
      check("loop_hi_len", lastHiLen, 2);
      check("loop_cs_untouched", sdCS, 1'b1);
      check("loop_idle_mosi", sdMOSI, 1'b1);

      // Chip-select control around a transfer
      d0 = doneCnt;
      doOp(spiopCSL, 8'h00, lat);
      check("csl_lat", lat, 1);
      check("csl_cs", sdCS, 1'b0);
      csWatch = 1'b1;
      doOp(spiopTR, 8'h40, lat);
      csWatch = 1'b0;
      check("cs_tr_lat", lat, 33);
      check("cs_tr_rxd", spiRXD, 8'h40);
      check("cs_low_during_tr", csViol, 0);
      doOp(spiopCSH, 8'h00, lat);
      check("csh_lat", lat, 1);
      check("csh_cs", sdCS, 1'b1);
      check("cs_done_pulses", doneCnt - d0, 3);

      // Slow mode with responder returning 01
      doOp(spiopSLOW, 8'h00, lat);
      check("slow_lat", lat, 1);
      loopMode = 1'b0;
      respByte = 8'h01;
      riseBase = riseCnt;
      doOp(spiopTR, 8'hFF, lat);
      check("slow_lat_tr", lat, 16 * 63 + 1);
      check("slow_rxd", spiRXD, 8'h01);
      check("slow_hi_len", lastHiLen, 63);

      // Busy rejection: FAST and CSH presented during a slow transfer
      doOp(spiopCSL, 8'h00, lat);
      respByte = 8'h3C;
      riseBase = riseCnt;
      startOp(spiopTR, 8'hFF);
      lat = 1;
      cyc(10);
      lat += 10;
      spiOP = spiopFAST;
      cyc(1);
      lat++;
      spiOP = spiopCSH;
      cyc(100);
      lat += 100;
      spiOP = spiopNOP;
      waitDone(lat);
      check("busy_tr_lat", lat, 16 * 63 + 1);
      check("busy_tr_rxd", spiRXD, 8'h3C);
      check("busy_cs_kept", sdCS, 1'b0);
      cyc(1);
      respByte = 8'hC3;
      riseBase = riseCnt;
      doOp(spiopTR, 8'h00, lat);
      check("busy_speed_kept", lat, 16 * 63 + 1);
      check("busy_rxd2", spiRXD, 8'hC3);

      // Dummy clocks (CS currently low, slow mode)
      d0 = doneCnt;
      r0 = riseCnt;
`ifdef SD_SPI_DUMMY_EN
      dumWatch = 1'b1;
      doOp(spiopDUMMY, 8'h00, lat);
      dumWatch = 1'b0;
      check("dummy_lat", lat, 10 * 16 * 63 + 1);
      check("dummy_rises", riseCnt - r0, 80);
      check("dummy_cs_mosi_high", dumViol, 0);
      check("dummy_done_pulses", doneCnt - d0, 1);
      check("dummy_rxd_kept", spiRXD, 8'hC3);
      check("dummy_cs_restored", sdCS, 1'b0);
`else
      startOp(spiopDUMMY, 8'h00);
      check("dummy_not_busy", spiBUSY, 1'b0);
      cyc(200);
      check("dummy_no_sclk", riseCnt - r0, 0);
      check("dummy_no_done", doneCnt - d0, 0);
      check("dummy_cs_kept", sdCS, 1'b0);
`endif

      // Reset in the HI phase of bit 4 of a fast transfer
      doOp(spiopFAST, 8'h00, lat);
      loopMode = 1'b1;
      d0 = doneCnt;
      r0 = riseCnt;
      startOp(spiopTR, 8'h00);
      lat = 0;
      while (riseCnt - r0 < 5 && lat < 200) begin
         cyc(1);
         lat++;
      end
      check("midrst_reached_bit4", riseCnt - r0, 5);
      check("midrst_in_hi", sdSCLK, 1'b1);
      check("midrst_mosi_bit", sdMOSI, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("midrst_cs", sdCS, 1'b1);
      check("midrst_sclk", sdSCLK, 1'b0);
      check("midrst_mosi", sdMOSI, 1'b1);
      check("midrst_busy", spiBUSY, 1'b0);
      #1 reset = 1'b0;
      cyc(50);
      check("midrst_no_done", doneCnt - d0, 0);

      // Synchronous clear aborts a transfer and restores slow speed
      doOp(spiopCSL, 8'h00, lat);
      d0 = doneCnt;
      startOp(spiopTR, 8'h00);
      cyc(5);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check("clr_cs", sdCS, 1'b1);
      check("clr_busy", spiBUSY, 1'b0);
      check("clr_sclk", sdSCLK, 1'b0);
      cyc(40);
      check("clr_no_done", doneCnt - d0, 0);
      doOp(spiopTR, 8'h5A, lat);
      check("clr_slow_lat", lat, 16 * 63 + 1);
      check("clr_loop_rxd", spiRXD, 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sd_spi_engine
`default_nettype wire
